// File: rtl/calc_disp_pkg.sv
// calc_disp_pkg: shared state encoding, segment patterns and sizing helper for the result display
package calc_disp_pkg;
  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    LOAD  = 4'b0010,
    SHIFT = 4'b0100,
    DONE  = 4'b1000
  } state_t;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/calc_result_display_ssd_decoder.sv
// ssd_decoder: 4-bit BCD digit to active-low {g..a} segment pattern, codes A-F blank
module ssd_decoder
  import calc_disp_pkg::*;
(
  input  logic [3:0] Digit,
  output logic [6:0] Seg
);
  // pure lookup; non-decimal codes light nothing
  always_comb begin
    case (Digit)
      4'd0:    Seg = SEG_0;
      4'd1:    Seg = SEG_1;
      4'd2:    Seg = SEG_2;
      4'd3:    Seg = SEG_3;
      4'd4:    Seg = SEG_4;
      4'd5:    Seg = SEG_5;
      4'd6:    Seg = SEG_6;
      4'd7:    Seg = SEG_7;
      4'd8:    Seg = SEG_8;
      4'd9:    Seg = SEG_9;
      default: Seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/calc_result_display.sv
// calc_result_display: double-dabble BCD converter and muxed 7-seg driver; CALC_DISP_LEADING_ZERO_BLANK_EN blanks leading zeros
module calc_result_display
  import calc_disp_pkg::*;
#(
  parameter int BIN_W  = 17,
  parameter int DIGITS = 6,
  parameter int SCAN_W = 18
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [BIN_W-1:0]      Bin_In,
  input  logic                  Flag_In,
  input  logic                  Start,
  output logic                  Busy,
  output logic                  Valid,
  output logic [4*DIGITS-1:0]   BCD_Out,
  output logic [DIGITS-1:0]     An,
  output logic [6:0]            Ssd,
  output logic                  Dp
);
  localparam int CW = cnt_width(BIN_W);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int BW = 4 * DIGITS;
  state_t            state;
  logic [BIN_W-1:0]  shift, shift_nxt;
  logic [BW-1:0]     scratch, adj, scratch_nxt;
  logic [CW-1:0]     cnt;
  logic              flag;
  logic [SCAN_W-1:0] presc;
  logic [IW-1:0]     idx;
  logic [3:0]        digit;
  // add-3 correction on every scratch digit that would overflow when doubled
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = scratch[4*i +: 4] >= 4'd5 ? scratch[4*i +: 4] + 4'd3 : scratch[4*i +: 4];
  end
  assign {scratch_nxt, shift_nxt} = {adj[BW-2:0], shift, 1'b0};
  // conversion FSM; operands are captured on the accepted Start so Bin_In may change afterwards
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      Busy    <= 1'b0;
      Valid   <= 1'b0;
      BCD_Out <= '0;
      flag    <= 1'b0;
      shift   <= '0;
      scratch <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          state   <= LOAD;
          Busy    <= 1'b1;
          shift   <= Bin_In;
          flag    <= Flag_In;
          scratch <= '0;
          cnt     <= CW'(BIN_W);
        end
        LOAD: state <= SHIFT;
        SHIFT: begin
          scratch <= scratch_nxt;
          shift   <= shift_nxt;
          cnt     <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state   <= DONE;
            Valid   <= 1'b1;
            BCD_Out <= scratch_nxt;
          end
        end
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Valid <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Valid <= 1'b0;
        end
      endcase
    end
  end
  // free-running refresh prescaler; digit slot advances on each wrap
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= presc + 1'b1;
      if (&presc) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
    end
  end
  assign digit = BCD_Out[4*idx +: 4];
  ssd_decoder u_dec (
    .Digit(digit),
    .Seg  (Ssd)
  );
  assign Dp = ~(flag & (idx == '0));
`ifdef CALC_DISP_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] shown;
  logic              seen;
  // a digit is lit if it or any more-significant digit is nonzero; digit 0 always lit
  always_comb begin
    shown    = '0;
    seen     = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      seen     = seen | (|BCD_Out[4*i +: 4]);
      shown[i] = seen;
    end
    shown[0] = 1'b1;
  end
  assign An = ~(shown & (DIGITS'(1) << idx));
`else
  assign An = ~(DIGITS'(1) << idx);
`endif
endmodule

// File: tb/tb_calc_result_display.sv
// tb_calc_result_display: randomized self-checking bench against a decimal-arithmetic reference model
module tb_calc_result_display;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [16:0] Bin_In = '0;
  logic        Flag_In = 1'b0;
  logic        Start = 1'b0;
  logic        Busy, Valid, Dp;
  logic [23:0] BCD_Out;
  logic [5:0]  An;
  logic [6:0]  Ssd;
  int compared = 0;
  int mismatched = 0;
  int n = 0;
  int mval = 0;
  logic mflag = 1'b0;
  localparam logic [6:0] SEG_ON [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  calc_result_display #(.BIN_W(17), .DIGITS(6), .SCAN_W(2)) dut (
    .Clk(Clk), .Reset(Reset), .Bin_In(Bin_In), .Flag_In(Flag_In), .Start(Start),
    .Busy(Busy), .Valid(Valid), .BCD_Out(BCD_Out), .An(An), .Ssd(Ssd), .Dp(Dp)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) n <= Reset ? 0 : n + 1;

  function automatic int p10(input int i);
    int r = 1;
    for (int j = 0; j < i; j++) r = r * 10;
    return r;
  endfunction

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    for (int i = 0; i < 6; i++) r[4*i +: 4] = 4'((v / p10(i)) % 10);
    return r;
  endfunction

  task automatic check_display(input int cycles);
    int idx;
    logic [5:0] e_an;
    logic [6:0] e_ssd;
    logic e_dp;
    for (int c = 0; c < cycles; c++) begin
      @(posedge Clk); #1;
      idx   = (n / 4) % 6;
      e_an  = ~(6'(1) << idx);
`ifdef CALC_DISP_LEADING_ZERO_BLANK_EN
      if (idx != 0 && mval < p10(idx)) e_an = 6'h3F;
`endif
      e_ssd = ~SEG_ON[(mval / p10(idx)) % 10];
      e_dp  = !(mflag && idx == 0);
      compared++;
      if ({An, Ssd, Dp} !== {e_an, e_ssd, e_dp}) begin
        mismatched++;
        $display("FAIL display slot %0d: An/Ssd/Dp got %b/%b/%b expected %b/%b/%b", idx, An, Ssd, Dp, e_an, e_ssd, e_dp);
      end
    end
  endtask

  task automatic conv(input int v, input logic f, input int extra, input int rst_at);
    int valids = 0;
    logic aborted = 1'b0;
    @(negedge Clk);
    Bin_In = 17'(v); Flag_In = f; Start = 1'b1;
    for (int k = 0; k < 26; k++) begin
      @(posedge Clk); #1;
      Start = (k == extra);
      Bin_In = 17'($urandom); Flag_In = 1'($urandom);
      if (k == rst_at) begin
        Reset = 1'b1; aborted = 1'b1; mval = 0; mflag = 1'b0; #1;
      end else if (rst_at >= 0 && k == rst_at + 1) Reset = 1'b0;
      compared++;
      if ({Busy, Valid} !== {!aborted && k <= 18, !aborted && k == 18}) begin
        mismatched++;
        $display("FAIL timing %0d cycle %0d: Busy/Valid got %b/%b expected %b/%b", v, k + 1, Busy, Valid, !aborted && k <= 18, !aborted && k == 18);
      end
      if (Valid === 1'b1) valids++;
      if (k == 18 && !aborted) begin
        compared++;
        if (BCD_Out !== to_bcd(v)) begin
          mismatched++;
          $display("FAIL bcd_at_valid %0d: got %h expected %h", v, BCD_Out, to_bcd(v));
        end
      end
    end
    Start = 1'b0;
    compared++;
    if (valids != (aborted ? 0 : 1)) begin
      mismatched++;
      $display("FAIL valid_count %0d: got %0d expected %0d", v, valids, aborted ? 0 : 1);
    end
    if (!aborted) begin mval = v; mflag = f; end
    compared++;
    if (BCD_Out !== to_bcd(mval)) begin
      mismatched++;
      $display("FAIL bcd_hold %0d: got %h expected %h", v, BCD_Out, to_bcd(mval));
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge Clk);
    #1;
    compared++;
    if ({Busy, Valid, BCD_Out, An, Ssd, Dp} !== {1'b0, 1'b0, 24'h0, 6'b111110, 7'b1000000, 1'b1}) begin
      mismatched++;
      $display("FAIL reset: Busy/Valid/BCD/An/Ssd/Dp got %b/%b/%h/%b/%b/%b expected 0/0/000000/111110/1000000/1", Busy, Valid, BCD_Out, An, Ssd, Dp);
    end
    @(negedge Clk); Reset = 1'b0;
    check_display(8);
  endtask

  task automatic test_directed;
    conv(12345, 1'b0, -1, -1);  check_display(30);
    conv(131071, 1'b1, -1, -1); check_display(30);
    conv(0, 1'b0, -1, -1);      check_display(30);
  endtask

  task automatic test_busy_ignore;
    conv(987, 1'b0, 4, -1);
    check_display(30);
  endtask

  task automatic test_reset_mid;
    conv(54321, 1'b1, -1, 7);
    check_display(12);
    conv(7, 1'b0, -1, -1);
    check_display(30);
  endtask

  task automatic test_scan;
    conv(123456, 1'b0, -1, -1);
    check_display(52);
  endtask

  task automatic test_back_to_back;
    conv(4321, 1'b1, 18, -1);
    conv(99999, 1'b0, -1, -1);
    check_display(26);
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++) begin
      conv(int'($urandom_range(0, 131071)), 1'($urandom), -1, -1);
      check_display(26);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_busy_ignore;
    test_reset_mid;
    test_scan;
    test_back_to_back;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
